// File: rtl/bus_pkg.sv
// Shared host-bus definitions for devices sitting on the device side of the bus hub.
// Holds bus widths, the device transaction state type and the address-window predicate.
package bus_pkg;

   localparam int BUS_ADDR_W = 32;
   localparam int BUS_DATA_W = 32;
   localparam int BUS_MASK_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } bus_dev_state_t;

   // Compared one bit wider so a window touching the top of the address space cannot wrap.
   function automatic logic in_window(input logic [BUS_ADDR_W-1:0] addr,
                                      input logic [BUS_ADDR_W-1:0] base,
                                      input logic [BUS_ADDR_W:0]   span_bytes);
      logic [BUS_ADDR_W:0] addr_ext;
      logic [BUS_ADDR_W:0] base_ext;
      addr_ext = {1'b0, addr};
      base_ext = {1'b0, base};
      return (addr_ext >= base_ext) && (addr_ext < (base_ext + span_bytes));
   endfunction

endpackage

// File: rtl/bus_ram_device_if.sv
// Hub-to-device bus bundle for a single memory-mapped device.
// The hub drives the request side (master); the device answers with data, ready and its window flag (slave).
interface bus_ram_device_if;
   import bus_pkg::*;

   logic [BUS_ADDR_W-1:0] address;
   logic [BUS_DATA_W-1:0] data_write;
   logic [BUS_MASK_W-1:0] write_mask;
   logic                  ren;
   logic                  wen;
   logic [BUS_DATA_W-1:0] data_read;
   logic                  ready;
   logic                  active;

   modport master (
      output address, data_write, write_mask, ren, wen,
      input  data_read, ready, active
   );

   modport slave (
      input  address, data_write, write_mask, ren, wen,
      output data_read, ready, active
   );

endinterface

// File: rtl/bus_ram_array.sv
// Word-organised storage for bus_ram_device: byte-masked synchronous write, synchronous read, no reset.
// A read and write to the same word on one edge returns the word as it was before the write.
module bus_ram_array
   import bus_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int INDEX_W     = $clog2(DEPTH_WORDS)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic                  re,
   input  logic [INDEX_W-1:0]    index,
   input  logic [BUS_DATA_W-1:0] wdata,
   input  logic [BUS_MASK_W-1:0] wmask,
   output logic [BUS_DATA_W-1:0] rdata
);

   logic [BUS_DATA_W-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (re) begin
         rdata <= mem[index];
      end
      if (we) begin
         for (int k = 0; k < BUS_MASK_W; k++) begin
            if (wmask[k]) begin
               mem[index][8*k +: 8] <= wdata[8*k +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/bus_ram_device.sv
// Memory-mapped word RAM on the host bus: decodes its own window, applies wait states,
// commits reads/writes on the edge entering RESP and pulses ready for one cycle.
module bus_ram_device
   import bus_pkg::*;
#(
   parameter logic [BUS_ADDR_W-1:0] BASE_ADDR   = 32'h1000_0000,
   parameter int                    DEPTH_WORDS = 256,
   parameter int                    WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   bus_ram_device_if.slave   bus
);

   localparam int                    INDEX_W      = $clog2(DEPTH_WORDS);
   localparam logic [BUS_ADDR_W:0]   WINDOW_BYTES = (BUS_ADDR_W+1)'(DEPTH_WORDS) << 2;
   localparam logic [3:0]            WAIT_LOAD    = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   bus_dev_state_t        state;
   logic [3:0]            count;
   logic                  ready_q;
   logic                  read_seen;
   logic [INDEX_W-1:0]    lat_index;
   logic [BUS_DATA_W-1:0] lat_data;
   logic [BUS_MASK_W-1:0] lat_mask;
   logic                  lat_write;
   logic                  lat_read;

   logic [BUS_ADDR_W-1:0] offset;
   logic [INDEX_W-1:0]    live_index;
   logic                  unused_offset_bits;
   logic                  request;
   logic                  commit;
   logic                  use_live;
   logic [INDEX_W-1:0]    cur_index;
   logic [BUS_DATA_W-1:0] cur_data;
   logic [BUS_MASK_W-1:0] cur_mask;
   logic                  cur_write;
   logic                  cur_read;
   logic [BUS_DATA_W-1:0] ram_rdata;

   assign offset             = bus.address - BASE_ADDR;
   assign live_index         = offset[INDEX_W+1:2];
   assign unused_offset_bits = ^{offset[BUS_ADDR_W-1:INDEX_W+2], offset[1:0]};
   assign bus.active         = in_window(bus.address, BASE_ADDR, WINDOW_BYTES);
   assign request            = (bus.ren | bus.wen) & bus.active;

   // With zero wait states the commit happens on the sampling edge, so live bus values feed the array.
   assign use_live  = (state == IDLE);
   assign cur_index = use_live ? live_index     : lat_index;
   assign cur_data  = use_live ? bus.data_write : lat_data;
   assign cur_mask  = use_live ? bus.write_mask : lat_mask;
   assign cur_write = use_live ? bus.wen        : lat_write;
   assign cur_read  = use_live ? bus.ren        : lat_read;

   always_comb begin
      commit = 1'b0;
      if (state == IDLE) begin
         commit = request && (WAIT_STATES == 0);
      end else if (state == WAIT) begin
         commit = (bus.ren | bus.wen) && (count == 4'd0);
      end
   end

   bus_ram_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .INDEX_W     (INDEX_W)
   ) u_array (
      .clk   (clk),
      .we    (commit & cur_write),
      .re    (commit & cur_read),
      .index (cur_index),
      .wdata (cur_data),
      .wmask (cur_mask),
      .rdata (ram_rdata)
   );

   // The array read register has no reset, so data_read reads zero until the first read completes.
   assign bus.data_read = read_seen ? ram_rdata : '0;
   assign bus.ready     = ready_q;

   // Transaction sequencer: IDLE samples, WAIT burns wait states or aborts, RESP shows ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         count     <= 4'd0;
         ready_q   <= 1'b0;
         read_seen <= 1'b0;
         lat_index <= '0;
         lat_data  <= '0;
         lat_mask  <= '0;
         lat_write <= 1'b0;
         lat_read  <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         if (commit && cur_read) begin
            read_seen <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (request) begin
                  lat_index <= live_index;
                  lat_data  <= bus.data_write;
                  lat_mask  <= bus.write_mask;
                  lat_write <= bus.wen;
                  lat_read  <= bus.ren;
                  if (WAIT_STATES == 0) begin
                     state   <= RESP;
                     ready_q <= 1'b1;
                  end else begin
                     state <= WAIT;
                     count <= WAIT_LOAD;
                  end
               end
            end
            WAIT: begin
               if (!(bus.ren | bus.wen)) begin
                  state <= IDLE;
               end else if (count == 4'd0) begin
                  state   <= RESP;
                  ready_q <= 1'b1;
               end else begin
                  count <= count - 4'd1;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_ram_device.sv
// Scoreboard bench for bus_ram_device: three instances (0, 1 and 3 wait states) share the request
// signals, stimulus queues expected responses and a negedge monitor checks every ready pulse.
module tb_bus_ram_device;
   import bus_pkg::*;

   typedef struct {
      int          dut;
      int          cycle;
      logic        check_data;
      logic [31:0] data;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] address;
   logic [31:0] data_write;
   logic [3:0]  write_mask;
   logic        ren;
   logic        wen;
   int          sel;
   int          cycle = 0;
   int          checks = 0;
   int          errors = 0;
   int          ws_of [3] = '{0, 1, 3};
   exp_t        exp_q [$];

   logic        ready_v  [3];
   logic        active_v [3];
   logic [31:0] rdata_v  [3];

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   bus_ram_device_if bus_ws0 ();
   bus_ram_device_if bus_ws1 ();
   bus_ram_device_if bus_ws3 ();

   assign bus_ws0.address = address;    assign bus_ws1.address = address;    assign bus_ws3.address = address;
   assign bus_ws0.data_write = data_write; assign bus_ws1.data_write = data_write; assign bus_ws3.data_write = data_write;
   assign bus_ws0.write_mask = write_mask; assign bus_ws1.write_mask = write_mask; assign bus_ws3.write_mask = write_mask;
   assign bus_ws0.ren = ren && (sel == 0); assign bus_ws1.ren = ren && (sel == 1); assign bus_ws3.ren = ren && (sel == 2);
   assign bus_ws0.wen = wen && (sel == 0); assign bus_ws1.wen = wen && (sel == 1); assign bus_ws3.wen = wen && (sel == 2);

   assign ready_v[0]  = bus_ws0.ready;     assign ready_v[1]  = bus_ws1.ready;     assign ready_v[2]  = bus_ws3.ready;
   assign active_v[0] = bus_ws0.active;    assign active_v[1] = bus_ws1.active;    assign active_v[2] = bus_ws3.active;
   assign rdata_v[0]  = bus_ws0.data_read; assign rdata_v[1]  = bus_ws1.data_read; assign rdata_v[2]  = bus_ws3.data_read;

   bus_ram_device #(.BASE_ADDR(32'h1000_0000), .DEPTH_WORDS(256), .WAIT_STATES(0)) dut_ws0 (
      .clk(clk), .rst_n(rst_n), .bus(bus_ws0));
   bus_ram_device #(.BASE_ADDR(32'h1000_0000), .DEPTH_WORDS(256), .WAIT_STATES(1)) dut_ws1 (
      .clk(clk), .rst_n(rst_n), .bus(bus_ws1));
   bus_ram_device #(.BASE_ADDR(32'h1000_0000), .DEPTH_WORDS(256), .WAIT_STATES(3)) dut_ws3 (
      .clk(clk), .rst_n(rst_n), .bus(bus_ws3));

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic pushExpect(input int dut, input int cyc, input logic chk, input logic [31:0] data,
                             input string name);
      exp_t e;
      e.dut        = dut;
      e.cycle      = cyc;
      e.check_data = chk;
      e.data       = data;
      e.name       = name;
      exp_q.push_back(e);
   endtask

   task automatic waitReady(input int dut, input string name);
      int waited = 0;
      do begin
         @(posedge clk); #1;
         waited++;
      end while (!ready_v[dut] && waited < 40);
      if (!ready_v[dut]) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s_timeout: got no ready after %0d cycles, expected ready", name, waited);
      end
   endtask

   // One complete transaction; the request is held until ready so wait states never look like an abort.
   task automatic applyStimulus(input int dut, input logic do_read, input logic do_write,
                                input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] mask,
                                input logic chk, input logic [31:0] exp_data, input string name);
      @(posedge clk); #1;
      sel        = dut;
      address    = addr;
      data_write = wdata;
      write_mask = mask;
      ren        = do_read;
      wen        = do_write;
      pushExpect(dut, cycle + 1 + ws_of[dut], chk, exp_data, name);
      waitReady(dut, name);
      ren = 1'b0;
      wen = 1'b0;
   endtask

   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (rst_n === 1'b1 && ready_v[d] === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_ready: dut %0d raised ready at cycle %0d, expected none", d, cycle);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               checkOutput({e.name, "_dut"}, 32'(d), 32'(e.dut));
               checkOutput({e.name, "_ready_cycle"}, 32'(cycle), 32'(e.cycle));
               if (e.check_data) begin
                  checkOutput({e.name, "_data"}, rdata_v[d], e.data);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0; sel = 0; address = '0; data_write = '0; write_mask = '0; ren = 1'b0; wen = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int d = 0; d < 3; d++) begin
         checkOutput("reset_ready", 32'(ready_v[d]), 32'd0);
         checkOutput("reset_data_read", rdata_v[d], 32'h0);
      end

      address = 32'h1000_03FC; #1 checkOutput("active_last_word", 32'(active_v[1]), 32'd1);
      address = 32'h1000_0000; #1 checkOutput("active_first_word", 32'(active_v[1]), 32'd1);
      address = 32'h1000_0400; #1 checkOutput("active_past_end", 32'(active_v[1]), 32'd0);
      address = 32'h0FFF_FFFC; #1 checkOutput("active_below_base", 32'(active_v[1]), 32'd0);

      // Out-of-window request must be ignored.
      @(posedge clk); #1;
      sel = 1; address = 32'h1000_0400; ren = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         checkOutput("outside_no_ready", 32'(ready_v[1]), 32'd0);
      end
      ren = 1'b0;

      applyStimulus(1, 1'b0, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0, "ws1_write");
      applyStimulus(1, 1'b1, 1'b0, 32'h1000_0010, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, "ws1_read");
      applyStimulus(1, 1'b0, 1'b1, 32'h1000_0020, 32'h1122_3344, 4'hF, 1'b0, 32'h0, "mask_preload");
      applyStimulus(1, 1'b0, 1'b1, 32'h1000_0020, 32'hAABB_CCDD, 4'b0101, 1'b0, 32'h0, "mask_write");
      applyStimulus(1, 1'b1, 1'b0, 32'h1000_0020, 32'h0, 4'h0, 1'b1, 32'h11BB_33DD, "mask_read");
      applyStimulus(1, 1'b0, 1'b1, 32'h1000_0020, 32'hFFFF_FFFF, 4'b0000, 1'b0, 32'h0, "mask_none_write");
      applyStimulus(1, 1'b1, 1'b0, 32'h1000_0022, 32'h0, 4'h0, 1'b1, 32'h11BB_33DD, "mask_none_read");
      applyStimulus(1, 1'b1, 1'b1, 32'h1000_0010, 32'h1234_5678, 4'hF, 1'b1, 32'hDEAD_BEEF, "rw_old_word");
      applyStimulus(1, 1'b1, 1'b0, 32'h1000_0010, 32'h0, 4'h0, 1'b1, 32'h1234_5678, "rw_new_word");

      // Abort on the three-wait-state instance: drop wen after one WAIT cycle.
      applyStimulus(2, 1'b0, 1'b1, 32'h1000_0030, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0, "abort_preload");
      @(posedge clk); #1;
      sel = 2; address = 32'h1000_0030; data_write = 32'h0; write_mask = 4'hF; wen = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      wen = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         checkOutput("abort_no_ready", 32'(ready_v[2]), 32'd0);
      end
      applyStimulus(2, 1'b1, 1'b0, 32'h1000_0030, 32'h0, 4'h0, 1'b1, 32'hCAFE_F00D, "abort_read");

      // Back-to-back reads with ren held high on the zero-wait-state instance.
      applyStimulus(0, 1'b0, 1'b1, 32'h1000_0000, 32'h0A0A_0A0A, 4'hF, 1'b0, 32'h0, "b2b_preload0");
      applyStimulus(0, 1'b0, 1'b1, 32'h1000_0004, 32'h0B0B_0B0B, 4'hF, 1'b0, 32'h0, "b2b_preload1");
      @(posedge clk); #1;
      sel = 0; address = 32'h1000_0000; ren = 1'b1;
      pushExpect(0, cycle + 1, 1'b1, 32'h0A0A_0A0A, "b2b_read0");
      waitReady(0, "b2b_read0");
      address = 32'h1000_0004;
      pushExpect(0, cycle + 2, 1'b1, 32'h0B0B_0B0B, "b2b_read1");
      waitReady(0, "b2b_read1");
      ren = 1'b0;

      // Reset during the WAIT phase of a write must leave the old word in place.
      applyStimulus(2, 1'b0, 1'b1, 32'h1000_0014, 32'h7777_7777, 4'hF, 1'b0, 32'h0, "rst_preload");
      applyStimulus(2, 1'b1, 1'b0, 32'h1000_0014, 32'h0, 4'h0, 1'b1, 32'h7777_7777, "rst_preread");
      @(posedge clk); #1;
      sel = 2; address = 32'h1000_0014; data_write = 32'h55; write_mask = 4'hF; wen = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      wen   = 1'b0;
      #1;
      checkOutput("rst_ready", 32'(ready_v[2]), 32'd0);
      checkOutput("rst_data_read", rdata_v[2], 32'h0);
      @(posedge clk); #1;
      checkOutput("rst_ready_held", 32'(ready_v[2]), 32'd0);
      rst_n = 1'b1;
      applyStimulus(2, 1'b1, 1'b0, 32'h1000_0014, 32'h0, 4'h0, 1'b1, 32'h7777_7777, "rst_word_kept");

      repeat (5) @(posedge clk);
      #1 checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
